// File: rtl/read_rsp_xbar.sv
// read_rsp_xbar: routes read responses from 4 cache banks to R_REQ_NUM ports.
// Per-output round-robin arbiter with burst lock and 2-entry registered buffer.
module read_rsp_xbar #(
    parameter int R_REQ_NUM   = 8,
    parameter int DATA_WIDTH  = 512,
    parameter int TXNID_WIDTH = 12,
    parameter int SB_WIDTH    = 8,
    parameter int DEST_W      = $clog2(R_REQ_NUM)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [3:0]                             bank_rsp_vld,
    input  logic [3:0][DATA_WIDTH-1:0]             bank_rsp_data,
    input  logic [3:0][TXNID_WIDTH-1:0]            bank_rsp_txnid,
    input  logic [3:0][SB_WIDTH-1:0]               bank_rsp_sideband,
    input  logic [3:0]                             bank_rsp_last,
    output logic [3:0]                             bank_rsp_rdy,
    output logic [R_REQ_NUM-1:0]                   rd_rsp_vld,
    output logic [R_REQ_NUM-1:0][DATA_WIDTH-1:0]   rd_rsp_data,
    output logic [R_REQ_NUM-1:0][TXNID_WIDTH-1:0]  rd_rsp_txnid,
    output logic [R_REQ_NUM-1:0][SB_WIDTH-1:0]     rd_rsp_sideband,
    output logic [R_REQ_NUM-1:0]                   rd_rsp_last,
    input  logic [R_REQ_NUM-1:0]                   rd_rsp_rdy,
    output logic                                   dest_err
);

    localparam int PW = DATA_WIDTH + TXNID_WIDTH + SB_WIDTH + 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;
    localparam logic [DEST_W:0] NUM_OUT = (DEST_W+1)'(R_REQ_NUM);

    logic [3:0][DEST_W-1:0]          dest;
    logic [3:0]                      in_rng;
    logic [3:0][PW-1:0]              bank_pl;
    logic [R_REQ_NUM-1:0][3:0]       req;
    logic [R_REQ_NUM-1:0]            gnt_vld;
    logic [R_REQ_NUM-1:0][1:0]       gnt_idx;
    logic [R_REQ_NUM-1:0]            acc;
    logic [R_REQ_NUM-1:0]            pop;
    logic [R_REQ_NUM-1:0][PW-1:0]    push_pl;

    logic [R_REQ_NUM-1:0]            state_q, state_d;
    logic [R_REQ_NUM-1:0][1:0]       lock_q, lock_d;
    logic [R_REQ_NUM-1:0][1:0]       ptr_q, ptr_d;
    logic [R_REQ_NUM-1:0][1:0]       cnt_q, cnt_d;
    logic [R_REQ_NUM-1:0]            vld_q, vld_d;
    logic [R_REQ_NUM-1:0][PW-1:0]    head_q, head_d;
    logic [R_REQ_NUM-1:0][PW-1:0]    tail_q, tail_d;
    logic                            dest_err_q, dest_err_d;

    // Extract destination port and pack each bank's beat.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            dest[b]    = bank_rsp_txnid[b][TXNID_WIDTH-1 -: DEST_W];
            in_rng[b]  = {1'b0, dest[b]} < NUM_OUT;
            bank_pl[b] = {bank_rsp_data[b], bank_rsp_txnid[b],
                          bank_rsp_sideband[b], bank_rsp_last[b]};
        end
    end

    // Per-output request vector, grant selection and buffer handshakes.
    always_comb begin
        logic [1:0] idx;
        idx = '0;
        for (int o = 0; o < R_REQ_NUM; o++) begin
            for (int b = 0; b < 4; b++) begin
                req[o][b] = bank_rsp_vld[b] && in_rng[b] &&
                            (dest[b] == DEST_W'(o));
            end
            gnt_vld[o] = 1'b0;
            gnt_idx[o] = '0;
            if (state_q[o] == ST_LOCK) begin
                gnt_vld[o] = req[o][lock_q[o]];
                gnt_idx[o] = lock_q[o];
            end else begin
                // Descending scan so the nearest bank from ptr wins last.
                for (int k = 3; k >= 0; k--) begin
                    idx = ptr_q[o] + 2'(k);
                    if (req[o][idx]) begin
                        gnt_vld[o] = 1'b1;
                        gnt_idx[o] = idx;
                    end
                end
            end
            acc[o]     = gnt_vld[o] && (cnt_q[o] != 2'd2);
            push_pl[o] = bank_pl[gnt_idx[o]];
            pop[o]     = vld_q[o] && rd_rsp_rdy[o];
        end
    end

    // Bank ready: granted and buffer has room, or out-of-range (dropped).
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            bank_rsp_rdy[b] = bank_rsp_vld[b] && !in_rng[b];
        end
        for (int o = 0; o < R_REQ_NUM; o++) begin
            for (int b = 0; b < 4; b++) begin
                if (acc[o] && (gnt_idx[o] == 2'(b))) begin
                    bank_rsp_rdy[b] = 1'b1;
                end
            end
        end
        bank_rsp_rdy = bank_rsp_rdy & {4{rst_n}};
    end

    // Arbiter state: lock on non-last beats, advance ptr after last.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        for (int o = 0; o < R_REQ_NUM; o++) begin
            if (acc[o]) begin
                if (push_pl[o][0]) begin
                    state_d[o] = ST_IDLE;
                    ptr_d[o]   = gnt_idx[o] + 2'd1;
                end else begin
                    state_d[o] = ST_LOCK;
                    lock_d[o]  = gnt_idx[o];
                end
            end
        end
    end

    // Two-entry buffer: head register feeds outputs, tail holds overflow.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        vld_d      = vld_q;
        dest_err_d = dest_err_q | (|(bank_rsp_vld & ~in_rng));
        for (int o = 0; o < R_REQ_NUM; o++) begin
            cnt_d[o] = cnt_q[o] + {1'b0, acc[o]} - {1'b0, pop[o]};
            if (pop[o]) begin
                head_d[o] = tail_q[o];
            end
            if (acc[o]) begin
                if (cnt_q[o] == 2'd0 || (cnt_q[o] == 2'd1 && pop[o])) begin
                    head_d[o] = push_pl[o];
                end else begin
                    tail_d[o] = push_pl[o];
                end
            end
            vld_d[o] = cnt_d[o] != 2'd0;
        end
    end

    // Output ports come straight from the head registers.
    always_comb begin
        rd_rsp_vld = vld_q;
        dest_err   = dest_err_q;
        for (int o = 0; o < R_REQ_NUM; o++) begin
            {rd_rsp_data[o], rd_rsp_txnid[o],
             rd_rsp_sideband[o], rd_rsp_last[o]} = head_q[o];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= '0;
            lock_q     <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            vld_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            dest_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            vld_q      <= vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            dest_err_q <= dest_err_d;
        end
    end

endmodule

// File: tb/tb_read_rsp_xbar.sv
// tb_read_rsp_xbar: randomized scoreboard bench for read_rsp_xbar.
// Reference keeps per-output queues and arbitration rules at beat level.
module tb_read_rsp_xbar;

    localparam int NREQ = 6;
    localparam int DW   = 64;
    localparam int TW   = 12;
    localparam int SB   = 8;
    localparam int DWD  = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        logic [SB-1:0] s;
        logic          l;
    } beat_t;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [3:0]                 bv;
    logic [3:0][DW-1:0]         bd;
    logic [3:0][TW-1:0]         bt;
    logic [3:0][SB-1:0]         bs;
    logic [3:0]                 bl;
    logic [3:0]                 brdy;
    logic [NREQ-1:0]            ov;
    logic [NREQ-1:0][DW-1:0]    od;
    logic [NREQ-1:0][TW-1:0]    ot;
    logic [NREQ-1:0][SB-1:0]    os;
    logic [NREQ-1:0]            ol;
    logic [NREQ-1:0]            ordy;
    logic                       derr;

    read_rsp_xbar #(
        .R_REQ_NUM(NREQ), .DATA_WIDTH(DW), .TXNID_WIDTH(TW), .SB_WIDTH(SB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .bank_rsp_vld(bv), .bank_rsp_data(bd), .bank_rsp_txnid(bt),
        .bank_rsp_sideband(bs), .bank_rsp_last(bl), .bank_rsp_rdy(brdy),
        .rd_rsp_vld(ov), .rd_rsp_data(od), .rd_rsp_txnid(ot),
        .rd_rsp_sideband(os), .rd_rsp_last(ol), .rd_rsp_rdy(ordy),
        .dest_err(derr)
    );

    always #5 clk = ~clk;

    beat_t expq [NREQ][$];
    int    ptr [NREQ];
    bit    lk [NREQ];
    int    lkb [NREQ];
    bit    full_pre [NREQ];
    bit    m_err;
    int    total = 0;
    int    bad = 0;
    int    phase = 0;
    int    burst_rem [4];
    int    bdest [4];
    bit    acc_dut [4];

    function automatic int dst(int b);
        return int'(bt[b][TW-1 -: DWD]);
    endfunction

    // Output monitor: compares each output against its expected queue.
    initial begin
        int    sz;
        beat_t got;
        beat_t tmp;
        forever begin
            @(negedge clk);
            for (int o = 0; o < NREQ; o++) begin
                sz = expq[o].size();
                full_pre[o] = (sz == 2);
                total++;
                if (ov[o] !== (sz != 0)) begin
                    bad++;
                    $display("FAIL out_vld[%0d] got=%b exp=%b t=%0t",
                             o, ov[o], (sz != 0), $time);
                end
                if (sz != 0 && ov[o] === 1'b1) begin
                    got = {od[o], ot[o], os[o], ol[o]};
                    total++;
                    if (got !== expq[o][0]) begin
                        bad++;
                        $display("FAIL out_beat[%0d] got=%h exp=%h t=%0t",
                                 o, got, expq[o][0], $time);
                    end
                    if (ordy[o]) tmp = expq[o].pop_front();
                end
            end
            total++;
            if (derr !== m_err) begin
                bad++;
                $display("FAIL dest_err got=%b exp=%b t=%0t",
                         derr, m_err, $time);
            end
        end
    end

    // Reference: predict bank ready and push accepted beats.
    task automatic model_step();
        logic [3:0] er;
        int    g;
        int    b;
        beat_t x;
        er = '0;
        for (int i = 0; i < 4; i++) acc_dut[i] = bv[i] && brdy[i];
        for (int i = 0; i < 4; i++) begin
            if (bv[i] && dst(i) >= NREQ) begin
                er[i] = 1'b1;
                m_err = 1'b1;
            end
        end
        for (int o = 0; o < NREQ; o++) begin
            g = -1;
            if (lk[o]) begin
                if (bv[lkb[o]] && dst(lkb[o]) == o) g = lkb[o];
            end else begin
                for (int k = 0; k < 4; k++) begin
                    b = (ptr[o] + k) % 4;
                    if (g < 0 && bv[b] && dst(b) == o) g = b;
                end
            end
            if (g >= 0 && !full_pre[o]) begin
                er[g] = 1'b1;
                x.d = bd[g]; x.t = bt[g]; x.s = bs[g]; x.l = bl[g];
                expq[o].push_back(x);
                if (bl[g]) begin
                    lk[o]  = 1'b0;
                    ptr[o] = (g + 1) % 4;
                end else begin
                    lk[o]  = 1'b1;
                    lkb[o] = g;
                end
            end
        end
        total++;
        if (brdy !== er) begin
            bad++;
            $display("FAIL bank_rdy got=%b exp=%b t=%0t", brdy, er, $time);
        end
    endtask

    // Stimulus: new beats replace accepted/idle ones, held otherwise.
    task automatic drive();
        bit idle;
        for (int b = 0; b < 4; b++) begin
            if (!bv[b] || acc_dut[b]) begin
                idle = (phase == 5) ||
                       ((phase == 0 || phase == 3 || phase == 4) &&
                        $urandom_range(0, 3) == 0);
                if (idle) begin
                    bv[b] = 1'b0;
                end else begin
                    if (burst_rem[b] == 0) begin
                        case (phase)
                            1:       begin bdest[b] = 3; burst_rem[b] = 1; end
                            2:       begin bdest[b] = b; burst_rem[b] = $urandom_range(1, 4); end
                            4:       begin bdest[b] = $urandom_range(0, 7); burst_rem[b] = $urandom_range(1, 4); end
                            default: begin bdest[b] = $urandom_range(0, NREQ-1); burst_rem[b] = $urandom_range(1, 4); end
                        endcase
                    end
                    bv[b] = 1'b1;
                    bd[b] = {$urandom, $urandom};
                    bt[b] = {3'(bdest[b]), 9'($urandom)};
                    bs[b] = 8'($urandom);
                    bl[b] = (burst_rem[b] == 1);
                    burst_rem[b]--;
                end
            end
            acc_dut[b] = 1'b0;
        end
        for (int o = 0; o < NREQ; o++) begin
            case (phase)
                1, 2, 5: ordy[o] = 1'b1;
                3:       ordy[o] = ($urandom_range(0, 9) < 3);
                default: ordy[o] = ($urandom_range(0, 9) < 7);
            endcase
        end
    endtask

    task automatic run(int ph, int n);
        phase = ph;
        repeat (n) begin
            drive();
            @(negedge clk); #1;
            model_step();
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_model();
        for (int o = 0; o < NREQ; o++) begin
            expq[o].delete();
            ptr[o] = 0;
            lk[o]  = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            burst_rem[b] = 0;
            acc_dut[b]   = 1'b0;
        end
        m_err = 1'b0;
        bv    = '0;
    endtask

    function automatic bit any_lock();
        bit r;
        r = 1'b0;
        for (int o = 0; o < NREQ; o++) r |= lk[o];
        return r;
    endfunction

    initial begin
        bv = '0; bd = '0; bt = '0; bs = '0; bl = '0; ordy = '0;
        clear_model();
        repeat (2) @(negedge clk);
        // Requests during reset must see no ready.
        bv = 4'hF;
        bl = 4'hF;
        #1;
        total++;
        if (brdy !== 4'h0) begin
            bad++;
            $display("FAIL rdy_in_reset got=%b exp=0000", brdy);
        end
        bv = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(1, 40);
        run(2, 40);
        run(3, 200);
        run(0, 300);
        for (int i = 0; i < 200; i++) begin
            if (any_lock()) break;
            run(0, 1);
        end
        // Asynchronous reset in the middle of traffic.
        rst_n = 1'b0;
        #1;
        total++;
        if (ov !== '0) begin
            bad++;
            $display("FAIL vld_mid_reset got=%b exp=0", ov);
        end
        total++;
        if (brdy !== 4'h0) begin
            bad++;
            $display("FAIL rdy_mid_reset got=%b exp=0000", brdy);
        end
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(0, 100);
        run(4, 400);
        run(5, 20);
        total++;
        if (derr !== 1'b1) begin
            bad++;
            $display("FAIL dest_err_sticky got=%b exp=1", derr);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/read_rsp_xbar.md
Name: read_rsp_xbar

Overview:
- Return-path crossbar that routes read responses from the 4 cache banks back to the R_REQ_NUM read requestors.
- It mirrors the N-to-4 read request crossbar: each beat is steered by a destination port ID carried in the upper bits of its txnid.
- Each output port has a round-robin arbiter over the 4 banks, burst locking on multi-beat responses, and a 2-entry output buffer. The buffer gives registered outputs at full throughput.

Parameters:
- R_REQ_NUM, 8, number of requestor (output) ports; range 2..16.
- DATA_WIDTH, 512, response data width in bits.
- TXNID_WIDTH, 12, txnid width; the top DEST_W bits carry the destination port ID.
- SB_WIDTH, 8, sideband width, passed through unchanged.
- DEST_W, $clog2(R_REQ_NUM), derived parameter; not intended to be overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- bank_rsp_vld  in  4  per-bank response valid.
- bank_rsp_data  in  [3:0][DATA_WIDTH]  response data.
- bank_rsp_txnid  in  [3:0][TXNID_WIDTH]  txnid; dest = txnid[TXNID_WIDTH-1 -: DEST_W].
- bank_rsp_sideband  in  [3:0][SB_WIDTH]  sideband.
- bank_rsp_last  in  4  last beat of the response.
- bank_rsp_rdy  out  4  per-bank ready.
- rd_rsp_vld  out  R_REQ_NUM  per-requestor valid.
- rd_rsp_data  out  [R_REQ_NUM-1:0][DATA_WIDTH]  data.
- rd_rsp_txnid  out  [R_REQ_NUM-1:0][TXNID_WIDTH]  txnid, unmodified.
- rd_rsp_sideband  out  [R_REQ_NUM-1:0][SB_WIDTH]  sideband.
- rd_rsp_last  out  R_REQ_NUM  last flag.
- rd_rsp_rdy  in  R_REQ_NUM  requestor ready.
- dest_err  out  1  sticky flag; set when a beat arrives with dest >= R_REQ_NUM.

Behaviour:
- Reset (async, rst_n=0):
  - all rd_rsp_vld=0, buffers empty, dest_err=0;
  - every RR pointer = bank 0, every lock cleared;
  - bank_rsp_rdy=0 while in reset.
  - Reset mid-burst discards buffered beats and locks; no partial-burst recovery.
- Handshake: a transfer occurs when vld&&rdy on the same edge.
  - vld, once high, holds with stable payload until accepted.
  - bank_rsp_rdy may depend combinationally on bank_rsp_vld and txnid.
  - rd_rsp_* outputs are driven only from registers.
- Routing:
  - Bank b requests output o when bank_rsp_vld[b] && dest(b)==o.
  - A bank requests at most one output per cycle.
- Per-output arbiter states:
  - IDLE: round-robin pick among requesting banks, starting at ptr and searching upward mod 4.
    - Winner accepted with last=1: ptr <- winner+1 mod 4, stay IDLE.
    - Winner accepted with last=0: go LOCKED(winner).
  - LOCKED(b): only bank b can be granted at this output.
    - Other banks targeting o see rdy=0.
    - On the accepted beat with last=1: ptr <- b+1 mod 4, return to IDLE.
    - A beat from b with a different dest does not break the lock; that beat stalls at its own output per that output's rules.
- bank_rsp_rdy[b] = (b granted at dest(b)) && buffer(dest(b)).count < 2.
- Output buffer (2-entry FIFO per output):
  - Push and pop are allowed in the same cycle; count is unchanged.
  - rd_rsp_vld[o] = count != 0; head entry is presented.
  - Latency: a beat accepted at edge k appears at rd_rsp_* after edge k, i.e. 1 cycle.
  - Sustained 1 beat/cycle per output when rd_rsp_rdy is held high.
  - Full (count==2) without pop: all banks see rdy=0 for that output; arbiter state and ptr unchanged.
- Ordering:
  - Per (bank, output) pair, beats are delivered in acceptance order.
  - Bursts are never interleaved at one output.
  - Different outputs are fully independent and concurrent; up to 4 transfers per cycle.
- Out-of-range dest (only possible when R_REQ_NUM is not a power of two):
  - beat accepted immediately (rdy=1) and dropped;
  - dest_err <- 1, held until reset;
  - no arbiter state is affected.
- Widths: every pointer/count update wraps modulo its field size; no saturation.

Test Plan:
- Single beat: bank 2 sends txnid dest=5, last=1, rd_rsp_rdy=all 1 → rd_rsp_vld[5]=1 exactly one cycle later with identical data/txnid/sideband; no other output valid.
- Fair contention: all 4 banks hold single-beat responses to dest 3 continuously, ptr=0 → grant order 0,1,2,3,0,… with one beat per cycle at output 3.
- Burst lock: bank 1 sends 4 beats (last on the 4th) to dest 0 while bank 0 also requests dest 0 → bank 0 rdy=0 for those 4 beats, and the output shows beats 1a..1d contiguous. Bank 0 wins next (ptr=2, banks 2/3 idle, wraps to 0).
- Backpressure: rd_rsp_rdy[4]=0 while bank 0 streams to dest 4 → 2 beats accepted, then bank_rsp_rdy[0]=0. After rdy is released, the output drains in order with no loss or duplication; the stream continues at 1/cycle.
- Parallel paths: banks 0..3 target dests 0..3 simultaneously every cycle → all 4 rdy=1 and 4 outputs valid each cycle.
- Reset mid-burst / error: assert rst_n=0 during a locked 3-beat burst → outputs drop immediately, locks clear, normal operation after release. With R_REQ_NUM=6, a beat to dest 7 → accepted, dropped, dest_err=1 sticky.
